// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, tick divisor and counter-width helpers.
// The transmitter reuses these.
package uart_pkg;

  localparam int unsigned DEF_SYSCLK = 10_000_000;
  localparam int unsigned DEF_BAUD   = 115_200;
  localparam int unsigned DEF_OSR    = 16;

  function automatic int unsigned calc_div(input int unsigned sysclk,
                                           input int unsigned baud,
                                           input int unsigned osr);
    return sysclk / (baud * osr);
  endfunction

  function automatic int unsigned tick_cnt_w(input int unsigned div);
    return $clog2(div) + 1;
  endfunction

  function automatic int unsigned os_cnt_w(input int unsigned osr);
    return $clog2(osr);
  endfunction

  localparam int unsigned DIV        = calc_div(DEF_SYSCLK, DEF_BAUD, DEF_OSR);
  localparam int unsigned TICK_CNT_W = tick_cnt_w(DIV);
  localparam int unsigned OS_CNT_W   = os_cnt_w(DEF_OSR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick generator: one-CLK TICK every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned SYSCLK = DEF_SYSCLK,
  parameter int unsigned BAUD   = DEF_BAUD,
  parameter int unsigned OSR    = DEF_OSR
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam int unsigned DIV_L = calc_div(SYSCLK, BAUD, OSR);
  localparam int unsigned CNT_W = tick_cnt_w(DIV_L);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_L - 1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   r_cnt <= '0;
    else if (r_cnt == CNT_LAST) r_cnt <= '0;
    else                       r_cnt <= r_cnt + CNT_W'(1);
  end

  assign TICK = (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_osr.sv
// 8N1 UART receiver with OSR-times oversampling; samples mid-bit and reports
// good bytes (RX_VALID) or bad stop bits (FRAME_ERR) at mid-stop-bit.
module uart_rx_osr
  import uart_pkg::*;
#(
  parameter int unsigned SYSCLK = DEF_SYSCLK,
  parameter int unsigned BAUD   = DEF_BAUD,
  parameter int unsigned OSR    = DEF_OSR
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int unsigned OS_W = os_cnt_w(OSR);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OSR / 2 - 1);
  localparam logic [OS_W-1:0] OS_FULL_LAST = OS_W'(OSR - 1);

  logic            w_tick;
  logic            r_sync1, r_sync2;
  logic [1:0]      r_fill;
  logic            r_line_prev;
  logic            w_fall;
  logic            w_start_pt, w_bit_pt;
  rx_state_t       r_state, w_next_state;
  logic [OS_W-1:0] r_os_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid, r_frame_err;

  uart_os_tick #(.SYSCLK(SYSCLK), .BAUD(BAUD), .OSR(OSR)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
    end
  end

  // The synchronizer's reset value is not a real observation of the line, so the
  // edge detector only arms once r_sync2 holds a genuinely sampled value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fill      <= 2'b00;
      r_line_prev <= 1'b0;
    end else begin
      r_fill      <= {r_fill[0], 1'b1};
      r_line_prev <= r_fill[1] & r_sync2;
    end
  end

  assign w_fall     = r_line_prev & ~r_sync2;
  assign w_start_pt = w_tick && (r_os_cnt == OS_HALF_LAST);
  assign w_bit_pt   = w_tick && (r_os_cnt == OS_FULL_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_fall)     w_next_state = START;
      START: if (w_start_pt) w_next_state = r_sync2 ? IDLE : DATA;
      DATA:  if (w_bit_pt && r_bit_idx == 3'd7) w_next_state = STOP;
      STOP:  if (w_bit_pt)   w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (r_state != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_os_cnt    <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: if (w_fall) r_os_cnt <= '0;
        START: if (w_tick) begin
          if (w_start_pt) begin
            r_os_cnt  <= '0;
            r_bit_idx <= 3'd0;
          end else begin
            r_os_cnt <= r_os_cnt + OS_W'(1);
          end
        end
        DATA: if (w_tick) begin
          if (w_bit_pt) begin
            r_os_cnt  <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_os_cnt <= r_os_cnt + OS_W'(1);
          end
        end
        STOP: if (w_tick) begin
          if (w_bit_pt) begin
            r_os_cnt <= '0;
            if (r_sync2) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_os_cnt <= r_os_cnt + OS_W'(1);
          end
        end
        default: r_os_cnt <= '0;
      endcase
    end
  end

  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_uart_rx_osr.sv
// Self-checking bench for uart_rx_osr at default parameters (80 CLK per bit).
module tb_uart_rx_osr;

  localparam int BIT_CLKS = 80;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int start_cyc;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_rx;
  } vec_t;

  ev_t  ev_q[$];
  ev_t  exp_q[$];
  vec_t vt[7];
  bit   prev_pulse = 1'b0;

  uart_rx_osr dut (
    .CLK       (CLK),
    .RST       (RST),
    .RXD       (RXD),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: records every output pulse and checks exclusivity and width.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RX_VALID || FRAME_ERR) begin
        check("pulse_exclusive", 32'(RX_VALID & FRAME_ERR), 32'd0);
        check("pulse_one_clk", 32'(prev_pulse), 32'd0);
        ev_q.push_back('{is_err: FRAME_ERR, data: RX_DATA, cyc: cyc});
      end
      prev_pulse = RX_VALID | FRAME_ERR;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    @(negedge CLK);
    RXD = v;
    repeat (n - 1) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(negedge CLK);
    RXD = 1'b0;
    start_cyc = cyc;
    repeat (BIT_CLKS - 1) @(negedge CLK);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(stop, BIT_CLKS);
  endtask

  function automatic int count_kind(input bit is_err);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].is_err == is_err) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] last_good;
    bit         seen_busy;
    int         lat, n;

    vt[0] = '{8'h11, 1'b1, 1, 0, 8'h11};
    vt[1] = '{8'h3C, 1'b0, 0, 1, 8'h11};
    vt[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vt[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vt[4] = '{8'h80, 1'b0, 0, 1, 8'hFF};
    vt[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vt[6] = '{8'h6E, 1'b0, 0, 1, 8'h01};

    RXD = 1'b1;
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("reset_rx_data", 32'(RX_DATA), 32'h00);
    check("reset_rx_valid", 32'(RX_VALID), 32'd0);
    check("reset_frame_err", 32'(FRAME_ERR), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    drive_bit(1'b1, 200);

    // Single good frame with latency window.
    ev_q.delete();
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, 40);
    check("a5_valid_count", 32'(count_kind(1'b0)), 32'd1);
    check("a5_ferr_count", 32'(count_kind(1'b1)), 32'd0);
    check("a5_rx_data", 32'(RX_DATA), 32'hA5);
    if (ev_q.size() > 0) begin
      lat = ev_q[0].cyc - start_cyc;
      check("a5_latency_in_window", 32'(lat >= 753 && lat <= 767), 32'd1);
    end

    for (int i = 0; i < 7; i++) begin
      ev_q.delete();
      send_frame(vt[i].data, vt[i].stop);
      drive_bit(1'b1, 40);
      check($sformatf("vec%0d_valid_count", i), 32'(count_kind(1'b0)), 32'(vt[i].exp_valid));
      check($sformatf("vec%0d_ferr_count", i), 32'(count_kind(1'b1)), 32'(vt[i].exp_ferr));
      check($sformatf("vec%0d_rx_data", i), 32'(RX_DATA), 32'(vt[i].exp_rx));
    end

    // 20-CLK glitch on an idle line.
    ev_q.delete();
    seen_busy = 1'b0;
    @(negedge CLK);
    RXD = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (BUSY) seen_busy = 1'b1;
    end
    RXD = 1'b1;
    n = 20;
    while (n < 48 && BUSY) begin
      @(negedge CLK);
      n++;
    end
    check("glitch_busy_seen", 32'(seen_busy), 32'd1);
    check("glitch_busy_cleared", 32'(BUSY), 32'd0);
    drive_bit(1'b1, 100);
    check("glitch_no_pulse", 32'(ev_q.size()), 32'd0);

    // Back-to-back frames, no idle between them.
    ev_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 40);
    check("b2b_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() >= 2) begin
      check("b2b_first", {23'd0, ev_q[0].is_err, ev_q[0].data}, {24'd0, 8'h00});
      check("b2b_second", {23'd0, ev_q[1].is_err, ev_q[1].data}, {24'd0, 8'hFF});
    end

    // Reset in the middle of bit 4, line held low across reset release.
    @(negedge CLK);
    RXD = 1'b0;
    repeat (BIT_CLKS * 5 + 39) @(negedge CLK);
    check("busy_before_reset", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check("async_reset_busy", 32'(BUSY), 32'd0);
    check("async_reset_rx_data", 32'(RX_DATA), 32'h00);
    check("async_reset_pulses", 32'({RX_VALID, FRAME_ERR}), 32'd0);
    repeat (10) @(negedge CLK);
    RST = 1'b0;
    ev_q.delete();
    repeat (30) @(negedge CLK);
    check("low_line_after_reset_no_start", 32'(BUSY), 32'd0);
    drive_bit(1'b1, 100);
    send_frame(8'h5A, 1'b1);
    drive_bit(1'b1, 40);
    check("post_reset_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1)
      check("post_reset_5a", {23'd0, ev_q[0].is_err, ev_q[0].data}, {24'd0, 8'h5A});

    // Break: line low for 2000 CLK.
    ev_q.delete();
    drive_bit(1'b0, 2000);
    drive_bit(1'b1, 300);
    check("break_count", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() >= 1)
      check("break_ferr_keeps_data", {23'd0, ev_q[0].is_err, ev_q[0].data}, {23'd0, 1'b1, 8'h5A});
    check("break_idle", 32'(BUSY), 32'd0);

    // Random frames against a frame-level model.
    ev_q.delete();
    exp_q.delete();
    last_good = 8'h5A;
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b;
      bit         stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? $urandom_range(0, 40) : $urandom_range(1, 40);
      send_frame(b, stop);
      if (gap > 0) drive_bit(1'b1, gap);
      if (stop) last_good = b;
      exp_q.push_back('{is_err: !stop, data: last_good, cyc: 0});
    end
    drive_bit(1'b1, 40);
    check("rand_event_count", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check($sformatf("rand_ev%0d", i), {23'd0, ev_q[i].is_err, ev_q[i].data},
            {23'd0, exp_q[i].is_err, exp_q[i].data});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_osr.md
UART_RX_OSR -- requirements
Module: uart_rx_osr

Interface
REQ-001 Parameter SYSCLK, default 10000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, nominal line bit rate.
REQ-003 Parameter OSR, default 16, oversample ticks per bit; even, at least 8.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 RXD  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-007 RX_DATA  output  8  last correctly framed byte.
REQ-008 RX_VALID  output  1  one-CLK pulse when RX_DATA is updated.
REQ-009 FRAME_ERR  output  1  one-CLK pulse when the stop bit samples low.
REQ-010 BUSY  output  1  high in every state except IDLE.

Function
REQ-011 The tick divisor SHALL be DIV = SYSCLK/(BAUD*OSR), using integer truncation; the defaults give DIV=5 and a bit period of 80 CLK.
REQ-012 A free-running tick counter SHALL count 0..DIV-1 and pulse an internal one-CLK tick when it reaches DIV-1, then wrap to 0.
REQ-013 RXD SHALL pass through a 2-FF synchronizer; both flops reset to 1; all decoding uses only the synchronized value.
REQ-014 The FSM SHALL have exactly these states: IDLE, START, DATA, STOP.
REQ-015 IDLE: on a synchronized high-to-low transition, go to START and clear the oversample counter; a line that is already low SHALL NOT trigger a start.
REQ-016 START: after OSR/2 ticks, sample the line; if low, go to DATA and clear the oversample counter and bit index; if high (glitch), return to IDLE with no output pulse.
REQ-017 DATA: every OSR ticks, sample the line into a shift register, LSB first; after bit index 7 is sampled, go to STOP.
REQ-018 STOP: after OSR ticks, sample the stop bit.
  - If the stop bit is 1: load RX_DATA from the shift register and pulse RX_VALID on the next CLK.
  - If the stop bit is 0: pulse FRAME_ERR and leave RX_DATA unchanged.
  - In both cases return to IDLE immediately, i.e. at mid-stop-bit.
REQ-019 RX_VALID and FRAME_ERR SHALL never be high in the same cycle, and each SHALL be high for exactly one CLK per frame.
REQ-020 Latency: the stop sample SHALL occur OSR/2 + 9*OSR ticks after the synchronized falling edge; the output pulse follows one CLK later.
REQ-021 A falling edge that arrives during START, DATA or STOP SHALL be treated as data and SHALL NOT restart the frame.
REQ-022 Back-to-back frames, where the next start edge directly follows the stop bit, SHALL be received with no lost byte.
REQ-023 The oversample counter width SHALL be $clog2(OSR); the tick counter width SHALL be $clog2(DIV)+1; neither counter SHALL overflow.

Reset
REQ-024 RST SHALL asynchronously force the following, at any time including mid-frame:
  - FSM to IDLE;
  - RX_DATA = 8'h00;
  - RX_VALID, FRAME_ERR and BUSY = 0;
  - all counters and the shift register to 0;
  - synchronizer flops to 1.
REQ-025 After RST is released, no start SHALL be detected until the synchronized line has been seen high and then low.

Structure
REQ-026 The state encodings, DIV and the counter-width constants SHALL live in the shared package uart_pkg, which the future transmitter also uses.
REQ-027 The tick generator SHALL be one sub-module, uart_os_tick (parameters SYSCLK, BAUD, OSR; ports CLK, RST, TICK), so that it can be shared with the transmitter; everything else stays in uart_rx_osr.

Verification
(Defaults throughout; bit period 80 CLK; bench drives RXD from CLK.)
REQ-028 Send 0xA5 with stop=1 -> RX_DATA=0xA5 and a single RX_VALID pulse about 760 CLK (+/- DIV+2) after the start edge; FRAME_ERR stays 0.
REQ-029 Drive a 20-CLK low glitch on an idle line -> BUSY returns to 0 within 48 CLK; no RX_VALID or FRAME_ERR pulse.
REQ-030 Receive 0x11, then send 0x3C with stop=0 -> one FRAME_ERR pulse, no RX_VALID, RX_DATA stays 0x11.
REQ-031 Send 0x00 then 0xFF back-to-back with zero idle time -> two RX_VALID pulses carrying 0x00 then 0xFF.
REQ-032 Assert RST during bit 4 of a frame, then resend 0x5A -> outputs return to reset values immediately; 0x5A is received correctly with no spurious pulse.
REQ-033 Hold RXD low for 2000 CLK (break), then release -> exactly one FRAME_ERR pulse; no further pulses until a new falling edge.
